// File: rtl/regfile_pkg.sv
// Shared types for the register-file write path.
// Used by the arbiter, hazard unit and MDU.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for MDU write requests.
// Push when full and pop when empty are ignored.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  wr_req_t i_data,
  output wr_req_t o_data,
  output logic o_full,
  output logic o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wr_req_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0] r_count;
  logic w_push;
  logic w_pop;

  assign o_full = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data = r_mem[r_rptr];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10: r_count <= r_count + 1'b1;
        2'b01: r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB and the MDU,
// and tracks registers with MDU results still in flight.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_reg,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic i_md_valid,
  output logic o_md_ready,
  input  logic [REG_ADDR_W-1:0] i_md_reg,
  input  logic [DATA_W-1:0] i_md_data,
  input  logic i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_reg,
  input  logic [REG_ADDR_W-1:0] i_chk_rs,
  input  logic [REG_ADDR_W-1:0] i_chk_rt,
  output logic o_stall,
  output logic o_wb_hold,
  output logic o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata
);
  localparam int NW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  wr_req_t w_md;
  wr_req_t w_head;
  logic w_full;
  logic w_empty;
  logic [NW:0] w_count;
  logic w_push;
  logic w_pop;
  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;
  logic [CW-1:0] r_starve;
  logic [CW-1:0] w_starve_nxt;

  assign w_md = '{addr: i_md_reg, data: i_md_data};
  assign o_md_ready = !w_full;
  assign w_push = i_md_valid && !w_full;
  assign w_pop = !i_wb_valid && (w_count != '0);
  assign o_stall = r_busy[i_chk_rs] | r_busy[i_chk_rt];

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data(w_md),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  // issue after clear so a same-edge set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.addr] = 1'b0;
    if (i_issue_valid) w_busy_nxt[i_issue_reg] = 1'b1;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_comb begin
    if (w_empty || w_pop) w_starve_nxt = '0;
    else if (r_starve < LIM) w_starve_nxt = r_starve + 1'b1;
    else w_starve_nxt = r_starve;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rf_we <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
      o_wb_hold <= 1'b0;
      r_busy <= '0;
      r_starve <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_starve <= w_starve_nxt;
      o_wb_hold <= (w_starve_nxt >= LIM);
      unique case (1'b1)
        i_wb_valid: begin
          o_rf_we <= (i_wb_reg != REG_ZERO);
          o_rf_waddr <= i_wb_reg;
          o_rf_wdata <= i_wb_data;
        end
        w_pop: begin
          o_rf_we <= (w_head.addr != REG_ZERO);
          o_rf_waddr <= w_head.addr;
          o_rf_wdata <= w_head.data;
        end
        default: o_rf_we <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter.
// Directed scenarios plus randomized traffic against a queue model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wb_valid = 1'b0;
  logic [4:0] wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic md_valid = 1'b0;
  logic md_ready;
  logic [4:0] md_reg = '0;
  logic [31:0] md_data = '0;
  logic issue_valid = 1'b0;
  logic [4:0] issue_reg = '0;
  logic [4:0] chk_rs = '0;
  logic [4:0] chk_rt = '0;
  logic stall;
  logic wb_hold;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .FIFO_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_wb_valid(wb_valid),
    .i_wb_reg(wb_reg),
    .i_wb_data(wb_data),
    .i_md_valid(md_valid),
    .o_md_ready(md_ready),
    .i_md_reg(md_reg),
    .i_md_data(md_data),
    .i_issue_valid(issue_valid),
    .i_issue_reg(issue_reg),
    .i_chk_rs(chk_rs),
    .i_chk_rt(chk_rt),
    .o_stall(stall),
    .o_wb_hold(wb_hold),
    .o_rf_we(rf_we),
    .o_rf_waddr(rf_waddr),
    .o_rf_wdata(rf_wdata)
  );

  typedef struct {
    logic we;
    logic [4:0] addr;
    logic [31:0] data;
    logic hold;
    logic ready;
    logic stall;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  wr_req_t m_q[$];
  bit m_busy[32];
  int m_wait;
  logic m_we;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  logic m_hold;
  bit md_acc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wait = 0;
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_hold = 1'b0;
    md_acc = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rf_we", rf_we, e.we);
        if (e.we) begin
          chk("rf_waddr", rf_waddr, e.addr);
          chk("rf_wdata", rf_wdata, e.data);
        end
        chk("wb_hold", wb_hold, e.hold);
        chk("md_ready", md_ready, e.ready);
        chk("stall", stall, e.stall);
      end
    end
  end

  // One cycle: drive inputs, queue expectations, advance model one edge
  task automatic step(input logic wv, input logic [4:0] wr,
                      input logic [31:0] wd, input logic mv,
                      input logic [4:0] mr, input logic [31:0] mdd,
                      input logic iv, input logic [4:0] ir,
                      input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    bit ready;
    bit had;
    bit popped;
    wr_req_t h;
    @(posedge clk);
    #1;
    if (md_acc) begin
      md_valid = 1'b0;
      md_acc = 1'b0;
    end
    if (!md_valid && mv) begin
      md_valid = 1'b1;
      md_reg = mr;
      md_data = mdd;
    end
    wb_valid = wv;
    wb_reg = wr;
    wb_data = wd;
    issue_valid = iv;
    issue_reg = ir;
    chk_rs = rs;
    chk_rt = rt;
    ready = (m_q.size() < DEPTH);
    e.we = m_we;
    e.addr = m_addr;
    e.data = m_data;
    e.hold = m_hold;
    e.ready = ready;
    e.stall = m_busy[rs] | m_busy[rt];
    exp_q.push_back(e);
    had = (m_q.size() > 0);
    popped = 1'b0;
    if (wv) begin
      m_we = (wr != 0);
      m_addr = wr;
      m_data = wd;
    end else if (had) begin
      h = m_q.pop_front();
      popped = 1'b1;
      m_we = (h.addr != 0);
      m_addr = h.addr;
      m_data = h.data;
      m_busy[h.addr] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    m_wait = (had && !popped) ? m_wait + 1 : 0;
    m_hold = (m_wait >= LIMIT);
    if (md_valid && ready) begin
      m_q.push_back('{addr: md_reg, data: md_data});
      md_acc = 1'b1;
    end
    if (iv && ir != 0) m_busy[ir] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // WB only
    step(1, 8, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // collision
    step(1, 3, 32'hAAAA, 1, 9, 32'h5555, 0, 0, 0, 0);
    idle(3);
    // full: WB busy while MDU offers three results
    step(1, 1, 32'h11, 1, 10, 32'hA0, 0, 0, 0, 0);
    step(1, 2, 32'h22, 1, 11, 32'hA1, 0, 0, 0, 0);
    step(1, 4, 32'h44, 1, 12, 32'hA2, 0, 0, 0, 0);
    step(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    // starvation
    step(1, 7, 32'h77, 1, 13, 32'hB0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(1, 5'(14 + i), 32'hC0 + i, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // scoreboard on reg 5, plus reg 0 traffic
    step(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    step(1, 2, 32'h2, 0, 0, 0, 1, 0, 5, 0);
    step(1, 2, 32'h3, 1, 5, 32'hDEAD, 0, 0, 5, 0);
    step(1, 2, 32'h4, 0, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    step(0, 0, 0, 1, 0, 32'hBEEF, 0, 0, 5, 0);
    step(1, 0, 32'hF00D, 0, 0, 0, 0, 0, 0, 5);
    idle(4);

    // reset mid-burst: two FIFO entries and busy[5]
    step(1, 8, 32'h80, 1, 9, 32'h90, 1, 5, 5, 0);
    step(1, 8, 32'h81, 1, 10, 32'h91, 0, 0, 5, 0);
    step(1, 8, 32'h82, 1, 11, 32'h92, 0, 0, 5, 9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    wb_valid = 1'b0;
    md_valid = 1'b0;
    issue_valid = 1'b0;
    chk_rs = 5;
    chk_rt = 9;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_hold", wb_hold, 0);
    chk("rst_ready", md_ready, 1);
    chk("rst_stall", stall, 0);
    @(posedge clk);
    #1;
    chk("rst2_we", rf_we, 0);
    chk("rst2_ready", md_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // randomized traffic with varying WB pressure
    for (int ph = 0; ph < 4; ph++) begin
      int pct;
      pct = (ph == 0) ? 30 : (ph == 1) ? 70 : (ph == 2) ? 95 : 50;
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < pct, 5'($urandom_range(0, 7)),
             $urandom, $urandom_range(0, 99) < 60,
             5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 99) < 20, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end
    idle(8);
    repeat (4) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
